// File: rtl/ascii_tx_pkg.sv
// Shared types and character constants for the ASCII stream transmitter.
package ascii_tx_pkg;

  typedef enum logic {
    IDLE,
    GAP
  } state_e;

  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_SUB      = 8'h3F;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  // Printable characters and LF pass through; everything else becomes '?'.
  function automatic logic [7:0] filter_byte(input logic [7:0] b);
    if (((b >= ASCII_PRINT_LO) && (b <= ASCII_PRINT_HI)) || (b == ASCII_LF)) begin
      return b;
    end
    return ASCII_SUB;
  endfunction

endpackage

// File: rtl/ascii_tx_fifo.sv
// Byte FIFO for the ASCII transmitter: registered storage, head reads the entry at the read pointer.
module ascii_tx_fifo #(
  parameter int unsigned p_depth = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);
  localparam int unsigned AW = $clog2(p_depth);
  localparam int unsigned CW = $clog2(p_depth + 1);

  logic [7:0]    mem_q [p_depth];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(p_depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ascii_stream_tx.sv
// Pops queued host bytes and emits them as single-cycle ascii_val pulses spaced p_gap idle cycles apart.
// Optional ASCII_TX_FILTER_EN replaces non-printable bytes (except LF) with '?' at the output register.
module ascii_stream_tx
  import ascii_tx_pkg::*;
#(
  parameter int unsigned p_depth = 16,
  parameter int unsigned p_gap   = 2
) (
  input  logic       clk_25M,
  input  logic       rst,
  input  logic [7:0] push_data,
  input  logic       push_val,
  output logic       push_rdy,
  output logic [7:0] ascii,
  output logic       ascii_val,
  output logic       busy
);
  localparam int unsigned GW = (p_gap > 0) ? $clog2(p_gap + 1) : 1;
`ifdef ASCII_TX_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    ascii_q, ascii_d;
  logic          val_q, val_d;
  logic          pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;

  ascii_tx_fifo #(
    .p_depth(p_depth)
  ) u_fifo (
    .clk        (clk_25M),
    .rst        (rst),
    .push_i     (push_val),
    .push_data_i(push_data),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

  assign push_rdy  = !fifo_full && !rst;
  assign busy      = !fifo_empty || (state_q != IDLE);
  assign ascii     = ascii_q;
  assign ascii_val = val_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ascii_d = ascii_q;
    val_d   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          ascii_d = FILTER_EN ? filter_byte(fifo_head) : fifo_head;
          val_d   = 1'b1;
          pop     = 1'b1;
          if (p_gap != 0) begin
            state_d = GAP;
            gap_d   = GW'(p_gap);
          end
        end
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      ascii_q <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ascii_q <= ascii_d;
      val_q   <= val_d;
    end
  end

endmodule

// File: tb/tb_ascii_stream_tx.sv
// Directed bench for ascii_stream_tx: p_gap=2 instance (dut_a) and p_gap=0 instance (dut_b).
module tb_ascii_stream_tx;
  logic       clk_25M = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data;
  logic       a_val, b_val;
  logic       a_rdy, b_rdy;
  logic [7:0] a_ascii, b_ascii;
  logic       a_aval, b_aval;
  logic       a_busy, b_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk_25M = ~clk_25M;

  ascii_stream_tx #(.p_depth(16), .p_gap(2)) dut_a (
    .clk_25M(clk_25M), .rst(rst), .push_data(a_data), .push_val(a_val),
    .push_rdy(a_rdy), .ascii(a_ascii), .ascii_val(a_aval), .busy(a_busy)
  );

  ascii_stream_tx #(.p_depth(16), .p_gap(0)) dut_b (
    .clk_25M(clk_25M), .rst(rst), .push_data(b_data), .push_val(b_val),
    .push_rdy(b_rdy), .ascii(b_ascii), .ascii_val(b_aval), .busy(b_busy)
  );

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic       ev;
    logic [7:0] ea;
    logic       eb;
    logic       er;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [7:0] exp_f(input logic [7:0] b);
`ifdef ASCII_TX_FILTER_EN
    if (((b >= 8'h20) && (b <= 8'h7E)) || (b == 8'h0A)) return b;
    return 8'h3F;
`else
    return b;
`endif
  endfunction

  function automatic vec_t mk(input logic pv, input logic [7:0] pd, input logic ev,
                              input logic [7:0] ea, input logic eb, input logic er);
    vec_t v;
    v.pv = pv; v.pd = pd; v.ev = ev; v.ea = ea; v.eb = eb; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_25M);
    #1;
  endtask

  // Order/spacing monitor for dut_a used during the fill/drain sequence.
  logic [7:0] q[$];
  int         gapc;
  int         npulse;

  task automatic mon_a();
    if (a_aval) begin
      if (q.size() == 0) chk("extra_byte", 1, 0);
      else chk("order", a_ascii, exp_f(q.pop_front()));
      if (npulse > 0) chk("gap_len", gapc, 2);
      npulse++;
      gapc = 0;
    end else begin
      gapc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bd[4];
    logic       saw_full;
    int         n;

    rst = 1'b1;
    a_val = 1'b0; a_data = '0;
    b_val = 1'b0; b_data = '0;

    tbl[0]  = mk(1, 8'h41, 0, 8'h00,          1, 1);
    tbl[1]  = mk(0, 8'h00, 1, 8'h41,          1, 1);
    tbl[2]  = mk(0, 8'h00, 0, 8'h41,          1, 1);
    tbl[3]  = mk(0, 8'h00, 0, 8'h41,          0, 1);
    tbl[4]  = mk(1, 8'h07, 0, 8'h41,          1, 1);
    tbl[5]  = mk(1, 8'h0A, 1, exp_f(8'h07),   1, 1);
    tbl[6]  = mk(1, 8'h7F, 0, exp_f(8'h07),   1, 1);
    tbl[7]  = mk(0, 8'h00, 0, exp_f(8'h07),   1, 1);
    tbl[8]  = mk(0, 8'h00, 1, 8'h0A,          1, 1);
    tbl[9]  = mk(0, 8'h00, 0, 8'h0A,          1, 1);
    tbl[10] = mk(0, 8'h00, 0, 8'h0A,          1, 1);
    tbl[11] = mk(0, 8'h00, 1, exp_f(8'h7F),   1, 1);
    tbl[12] = mk(0, 8'h00, 0, exp_f(8'h7F),   1, 1);
    tbl[13] = mk(0, 8'h00, 0, exp_f(8'h7F),   0, 1);

    // Reset state, then 20 idle cycles after release
    repeat (3) tick();
    chk("rst_rdy_a", a_rdy, 0);
    chk("rst_rdy_b", b_rdy, 0);
    chk("rst_val", a_aval, 0);
    chk("rst_ascii", a_ascii, 8'h00);
    chk("rst_busy", a_busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_val", a_aval, 0);
      chk("idle_ascii", a_ascii, 8'h00);
      chk("idle_busy", a_busy, 0);
      chk("idle_rdy", a_rdy, 1);
    end

    // Single push latency/hold plus filter sequence
    for (int i = 0; i < 14; i++) begin
      a_val  = tbl[i].pv;
      a_data = tbl[i].pd;
      tick();
      a_val = 1'b0;
      chk($sformatf("tbl%0d_val", i),   a_aval,  tbl[i].ev);
      chk($sformatf("tbl%0d_ascii", i), a_ascii, tbl[i].ea);
      chk($sformatf("tbl%0d_busy", i),  a_busy,  tbl[i].eb);
      chk($sformatf("tbl%0d_rdy", i),   a_rdy,   tbl[i].er);
    end

    // Fill until full, attempt one refused push, then drain and verify order/spacing
    saw_full = 1'b0;
    n = 0;
    gapc = 0;
    npulse = 0;
    for (int cyc = 0; cyc < 60 && !saw_full; cyc++) begin
      if (a_rdy) begin
        a_val  = 1'b1;
        a_data = 8'h30 + 8'(n);
        q.push_back(a_data);
        n++;
      end else begin
        saw_full = 1'b1;
        a_val  = 1'b1;
        a_data = 8'hEE;
      end
      tick();
      mon_a();
    end
    a_val = 1'b0;
    chk("full_reached", saw_full, 1);
    chk("accepted_ge16", (n >= 16), 1);
    for (int cyc = 0; cyc < 120 && (q.size() > 0 || a_busy); cyc++) begin
      tick();
      mon_a();
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_pulses", npulse, n);
    chk("drain_busy", a_busy, 0);
    tick();
    chk("no_refused_byte", a_aval, 0);

    // p_gap = 0: back-to-back pulses
    bd[0] = 8'hA1; bd[1] = 8'hA2; bd[2] = 8'hA3; bd[3] = 8'hA4;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        b_val  = 1'b1;
        b_data = bd[k];
      end else begin
        b_val = 1'b0;
      end
      tick();
      chk($sformatf("g0_val%0d", k), b_aval, ((k >= 1) && (k <= 4)));
      if ((k >= 1) && (k <= 4)) chk($sformatf("g0_ascii%0d", k), b_ascii, exp_f(bd[k-1]));
      chk($sformatf("g0_busy%0d", k), b_busy, (k < 4));
    end
    b_val = 1'b0;

    // Reset mid-pulse during GAP with bytes still queued
    for (int k = 0; k < 5; k++) begin
      a_val  = 1'b1;
      a_data = 8'hC1 + 8'(k);
      tick();
    end
    a_val = 1'b0;
    chk("pre_rst_val", a_aval, 1);
    chk("pre_rst_busy", a_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_val", a_aval, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_rdy", a_rdy, 0);
    chk("mid_rst_ascii", a_ascii, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("post_rst_val", a_aval, 0);
      chk("post_rst_busy", a_busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
